line_clear_ctrl: RTL and testbench

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

---
 rtl/line_clear_ctrl_pkg.sv | 22 ++
 rtl/line_clear_ctrl_row_shifter.sv | 33 +++
 rtl/line_clear_ctrl.sv | 119 +++++++++++
 tb/tb_line_clear_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/line_clear_ctrl_pkg.sv
// Shared board geometry, counter widths and FSM state encodings for line_clear_ctrl.
// Optional macro LINE_CLEAR_TOTAL_EN (used by the top) enables the running total accumulator.
package line_clear_ctrl_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int BOARD_BITS = BOARD_COLS * BOARD_ROWS;

    localparam int ROW_W   = 5;
    localparam int CNT_W   = 5;
    localparam int TOTAL_W = 16;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/line_clear_ctrl_row_shifter.sv
// Combinational row checker and collapser: reports whether row row_sel is full and
// produces the board with that row removed, upper rows dropped by one and zeros entering at the top.
module board_row_shifter
    import line_clear_ctrl_pkg::*;
(
    input  logic [BOARD_BITS-1:0] board,
    input  logic [ROW_W-1:0]      row_sel,
    output logic                  row_full,
    output logic [BOARD_BITS-1:0] shifted
);

    always_comb begin
        row_full = 1'b0;
        for (int i = 0; i < BOARD_ROWS; i++) begin
            if (row_sel == ROW_W'(i)) begin
                row_full = &board[i*BOARD_COLS +: BOARD_COLS];
            end
        end
    end

    // Rows below row_sel keep their contents; every other row takes the row above it.
    for (genvar i = 0; i < BOARD_ROWS; i++) begin : g_row
        if (i == BOARD_ROWS - 1) begin : g_top
            assign shifted[i*BOARD_COLS +: BOARD_COLS] =
                (ROW_W'(i) < row_sel) ? board[i*BOARD_COLS +: BOARD_COLS] : '0;
        end else begin : g_mid
            assign shifted[i*BOARD_COLS +: BOARD_COLS] =
                (ROW_W'(i) < row_sel) ? board[i*BOARD_COLS +: BOARD_COLS]
                                      : board[(i+1)*BOARD_COLS +: BOARD_COLS];
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear controller: scans a 10x20 board bottom-up, collapsing full rows one per SHIFT cycle.
// Define LINE_CLEAR_TOTAL_EN to build the saturating running total of cleared lines.
module line_clear_ctrl
    import line_clear_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BOARD_BITS-1:0] board_in,
    output logic                  busy,
    output logic                  done,
    output logic [BOARD_BITS-1:0] board_out,
    output logic [CNT_W-1:0]      lines_cleared,
    output logic [TOTAL_W-1:0]    total_lines
);

    state_t                state_q, state_d;
    logic [BOARD_BITS-1:0] board_q, board_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      lines_q, lines_d;

    logic                  row_full;
    logic [BOARD_BITS-1:0] shifted;

    board_row_shifter u_shifter (
        .board    (board_q),
        .row_sel  (row_q),
        .row_full (row_full),
        .shifted  (shifted)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            board_q <= '0;
            row_q   <= '0;
            count_q <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            row_q   <= row_d;
            count_q <= count_d;
            lines_q <= lines_d;
        end
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        row_d   = row_q;
        count_d = count_q;
        lines_d = lines_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    board_d = board_in;
                    row_d   = '0;
                    count_d = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (row_full) begin
                    state_d = ST_SHIFT;
                end else if (row_q < LAST_ROW) begin
                    row_d = row_q + 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            // Row pointer stays put so the row that dropped into place is checked next.
            ST_SHIFT: begin
                board_d = shifted;
                count_d = count_q + 1'b1;
                state_d = ST_SCAN;
            end
            ST_DONE: begin
                lines_d = count_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign board_out     = board_q;
    assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_TOTAL_EN
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [TOTAL_W:0]   total_sum;

    always_ff @(posedge clock) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    always_comb begin
        total_sum = {1'b0, total_q} + (TOTAL_W+1)'(count_q);
        total_d   = total_q;
        if (state_q == ST_DONE) begin
            total_d = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
        end
    end

    assign total_lines = total_q;
`else
    assign total_lines = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: table of boards with expected results,
// a scoreboard of expected pass outcomes, plus reset-abort and start-while-busy sequences.
module tb_line_clear_ctrl;

    logic         clock;
    logic         reset;
    logic         start;
    logic [199:0] board_in;
    logic         busy;
    logic         done;
    logic [199:0] board_out;
    logic [4:0]   lines_cleared;
    logic [15:0]  total_lines;

    line_clear_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [199:0] board;
        int           lines;
        logic [199:0] result;
    } vec_t;

    typedef struct {
        int           lines;
        logic [199:0] result;
        int           latency;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   total;
    int   bad;
    int   total_exp;

    task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: keep non-full rows in order, packed from the bottom.
    function automatic void model(input logic [199:0] b, output logic [199:0] res, output int k);
        int w;
        logic [9:0] row;
        w   = 0;
        k   = 0;
        res = '0;
        for (int i = 0; i < 20; i++) begin
            row = b[i*10 +: 10];
            if (row == 10'h3FF) begin
                k++;
            end else begin
                res[w*10 +: 10] = row;
                w++;
            end
        end
    endfunction

    // Called at a negedge; start is sampled on the very next rising edge.
    task automatic applyStimulus(input string tag, input logic [199:0] b, input int exp_lines,
                                 input logic [199:0] exp_res, input bit dup_start);
        exp_t e;
        exp_t got_e;
        int   edges;
        int   dones;
        bit   got;
        e.lines   = exp_lines;
        e.result  = exp_res;
        e.latency = 20 + 2 * exp_lines;
        sb.push_back(e);

        board_in = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        board_in = ~b;
        @(negedge clock);
        checkOutput({tag, "_busy"}, 200'(busy), 200'(1'b1));

        edges = 0;
        dones = 0;
        got   = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (dup_start) start = (edges == 3);
            if (done) got = 1'b1;
        end
        start = 1'b0;

        got_e = sb.pop_front();
        if (!got) begin
            checkOutput({tag, "_done_timeout"}, 200'(edges), 200'(got_e.latency));
        end else begin
            dones++;
            checkOutput({tag, "_latency"}, 200'(edges), 200'(got_e.latency));
            checkOutput({tag, "_board_at_done"}, board_out, got_e.result);
            @(posedge clock);
            @(negedge clock);
            if (done) dones++;
            checkOutput({tag, "_done_pulses"}, 200'(dones), 200'(1));
            checkOutput({tag, "_idle"}, 200'(busy), 200'(1'b0));
            checkOutput({tag, "_lines"}, 200'(lines_cleared), 200'(got_e.lines));
            checkOutput({tag, "_board"}, board_out, got_e.result);
            total_exp = total_exp + got_e.lines;
            if (total_exp > 65535) total_exp = 65535;
`ifdef LINE_CLEAR_TOTAL_EN
            checkOutput({tag, "_total"}, 200'(total_lines), 200'(total_exp));
`else
            checkOutput({tag, "_total"}, 200'(total_lines), 200'(0));
`endif
        end
    endtask

    initial begin
        logic [199:0] b;
        logic [199:0] res;
        logic [9:0]   row;
        int           k;
        bit           seen_done;

        total     = 0;
        bad       = 0;
        total_exp = 0;
        reset     = 1'b1;
        start     = 1'b0;
        board_in  = '1;

        b = '0;
        vecs[0] = '{board: b, lines: 0, result: b};

        b = '0; b[9:0] = 10'h3FF; b[19:10] = 10'h3FF; b[29:20] = 10'b0000000001;
        res = '0; res[9:0] = 10'b0000000001;
        vecs[1] = '{board: b, lines: 2, result: res};

        b = '0; b[39:30] = 10'h3FF; b[59:50] = 10'h3FF; b[49:40] = 10'b1010101010;
        res = '0; res[39:30] = 10'b1010101010;
        vecs[2] = '{board: b, lines: 2, result: res};

        b = '0; b[199:190] = 10'h3FF;
        vecs[3] = '{board: b, lines: 1, result: 200'b0};

        for (int v = 4; v < 8; v++) begin
            b = '0;
            for (int r = 0; r < 20; r++) begin
                row = 10'($urandom_range(0, 1023));
                if ($urandom_range(0, 2) == 0) row = 10'h3FF;
                b[r*10 +: 10] = row;
            end
            model(b, res, k);
            vecs[v] = '{board: b, lines: k, result: res};
        end

        b = '1;
        vecs[8] = '{board: b, lines: 20, result: 200'b0};

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_busy", 200'(busy), 200'(1'b0));
        checkOutput("reset_done", 200'(done), 200'(1'b0));
        checkOutput("reset_board", board_out, 200'b0);
        checkOutput("reset_lines", 200'(lines_cleared), 200'(0));
        checkOutput("reset_total", 200'(total_lines), 200'(0));

        for (int v = 0; v < 9; v++) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].board, vecs[v].lines, vecs[v].result, 1'b0);
        end

        // Abort a pass with reset on edge 5 after the start edge.
        b = '0; b[9:0] = 10'h3FF;
        board_in  = b;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        seen_done = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) seen_done = 1'b1;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        if (done) seen_done = 1'b1;
        total_exp = 0;
        checkOutput("abort_busy", 200'(busy), 200'(1'b0));
        checkOutput("abort_board", board_out, 200'b0);
        checkOutput("abort_lines", 200'(lines_cleared), 200'(0));
        checkOutput("abort_total", 200'(total_lines), 200'(0));
        checkOutput("abort_no_done", 200'(seen_done), 200'(1'b0));
        applyStimulus("after_abort", 200'b0, 0, 200'b0, 1'b0);

        applyStimulus("dup_start", vecs[1].board, vecs[1].lines, vecs[1].result, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
